// File: rtl/me_stage.sv
// Memory-access pipeline stage: latches execute results, holds first-cycle SRAM/multiplier
// data across stalls, owns HI/LO and forms the writeback result.
module me_stage #(
    parameter int DATA_W      = 32,
    parameter int LINK_OFFSET = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  EX_to_ME_valid,
    input  logic                  WB_allowin,
    input  logic [DATA_W-1:0]     EX_PC,
    input  logic [4:0]            EX_WriteReg,
    input  logic                  EX_RegWrite,
    input  logic [DATA_W-1:0]     EX_aluResult,
    input  logic                  EX_MemToReg,
    input  logic                  EX_Jal,
    input  logic                  EX_Mul,
    input  logic                  EX_SpecialRegWri,
    input  logic                  EX_SpecialRegRead,
    input  logic [1:0]            EX_SpecialRegSel,
    input  logic [DATA_W-1:0]     EX_HIVal,
    input  logic [DATA_W-1:0]     EX_LOVal,
    input  logic [2*DATA_W-1:0]   ME_MulRes,
    input  logic [DATA_W-1:0]     data_sram_rdata,
    output logic                  ME_allowin,
    output logic                  ME_to_WB_valid,
    output logic                  ME_valid,
    output logic [DATA_W-1:0]     ME_PC,
    output logic [4:0]            ME_WriteReg,
    output logic                  ME_RegWrite,
    output logic [DATA_W-1:0]     ME_Result,
    output logic [DATA_W-1:0]     ME_HI,
    output logic [DATA_W-1:0]     ME_LO
);
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [4:0]        write_reg;
        logic              reg_write;
        logic [DATA_W-1:0] alu_result;
        logic              mem_to_reg;
        logic              jal;
        logic              mul;
        logic              sreg_wri;
        logic              sreg_read;
        logic [1:0]        sreg_sel;
        logic [DATA_W-1:0] hi_val;
        logic [DATA_W-1:0] lo_val;
    } me_payload_t;

    me_payload_t          pl;
    logic                 first;
    logic [2*DATA_W-1:0]  mul_hold;
    logic [DATA_W-1:0]    ld_hold;
    logic [DATA_W-1:0]    hi_q, lo_q;
    logic                 accept, leave;
    logic [2*DATA_W-1:0]  eff_mul;
    logic [DATA_W-1:0]    eff_ld;

    assign ME_allowin     = !ME_valid || WB_allowin;
    assign ME_to_WB_valid = ME_valid;
    assign accept         = EX_to_ME_valid && ME_allowin;
    assign leave          = ME_valid && WB_allowin;

    // SRAM data and product are only valid in the first ME cycle; later cycles use the held copy
    assign eff_mul = first ? ME_MulRes : mul_hold;
    assign eff_ld  = first ? data_sram_rdata : ld_hold;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ME_valid <= 1'b0;
            pl       <= '0;
            first    <= 1'b0;
            mul_hold <= '0;
            ld_hold  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (ME_allowin) ME_valid <= EX_to_ME_valid;
            first <= accept;
            if (first) begin
                mul_hold <= ME_MulRes;
                ld_hold  <= data_sram_rdata;
            end
            if (accept) begin
                pl.pc         <= EX_PC;
                pl.write_reg  <= EX_WriteReg;
                pl.reg_write  <= EX_RegWrite;
                pl.alu_result <= EX_aluResult;
                pl.mem_to_reg <= EX_MemToReg;
                pl.jal        <= EX_Jal;
                pl.mul        <= EX_Mul;
                pl.sreg_wri   <= EX_SpecialRegWri;
                pl.sreg_read  <= EX_SpecialRegRead;
                pl.sreg_sel   <= EX_SpecialRegSel;
                pl.hi_val     <= EX_HIVal;
                pl.lo_val     <= EX_LOVal;
            end
            // commit on leave only, so a stalled instruction writes HI/LO exactly once
            if (leave && pl.sreg_wri) begin
                if (pl.mul || pl.sreg_sel[1]) hi_q <= pl.mul ? eff_mul[2*DATA_W-1:DATA_W] : pl.hi_val;
                if (pl.mul || pl.sreg_sel[0]) lo_q <= pl.mul ? eff_mul[DATA_W-1:0] : pl.lo_val;
            end
        end
    end

    always_comb begin
        ME_Result = pl.alu_result;
        if (pl.mem_to_reg)     ME_Result = eff_ld;
        else if (pl.jal)       ME_Result = pl.pc + DATA_W'(LINK_OFFSET);
        else if (pl.sreg_read) ME_Result = pl.sreg_sel[1] ? hi_q : lo_q;
    end

    assign ME_PC       = pl.pc;
    assign ME_WriteReg = pl.write_reg;
    assign ME_RegWrite = pl.reg_write && ME_valid;
    assign ME_HI       = hi_q;
    assign ME_LO       = lo_q;
endmodule
